// File: rtl/reg_display_scanner.sv
// Register-file viewer: picks one of NUM_REGS registers and shows it as hex digits,
// with debounced Next/Prev/Page buttons, auto-scan, freeze hold and paging of wide registers.

module reg_display_btn #(
  parameter int DEBOUNCE = 16
) (
  input  logic Clock,
  input  logic Reset,
  input  logic raw_i,
  output logic press_o
);
  localparam int DBW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  logic           sync1_q, sync2_q;
  logic           db_q, db_d;
  logic           press_q, press_d;
  logic [DBW-1:0] cnt_q, cnt_d;

  always_comb begin
    db_d    = db_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (sync2_q != db_q) begin
      if (cnt_q == DBW'(DEBOUNCE - 1)) begin
        db_d    = sync2_q;
        press_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      db_q    <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;
endmodule

module reg_display_scanner #(
  parameter  int NUM_REGS  = 8,
  parameter  int REG_WIDTH = 16,
  parameter  int DIGITS    = 4,
  parameter  int DEBOUNCE  = 16,
  parameter  int SCAN_DIV  = 1000,
  localparam int SELW      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
  localparam int PAGES     = (REG_WIDTH + 4*DIGITS - 1) / (4*DIGITS),
  localparam int PGW       = (PAGES > 1) ? $clog2(PAGES) : 1
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic [NUM_REGS*REG_WIDTH-1:0] Regs,
  input  logic                          Next,
  input  logic                          Prev,
  input  logic                          PageBtn,
  input  logic                          Auto,
  input  logic                          Freeze,
  output logic [SELW-1:0]               Sel,
  output logic [PGW-1:0]                Page,
  output logic [4*DIGITS-1:0]           Nibbles,
  output logic [DIGITS-1:0]             Blank
);
  localparam int NIBW = 4 * DIGITS;
  localparam int PADW = PAGES * NIBW;
  localparam int SCW  = $clog2(SCAN_DIV);

  function automatic logic [DIGITS-1:0] blank_pattern(input int pg);
    for (int d = 0; d < DIGITS; d++) begin
      blank_pattern[d] = ((pg * DIGITS + d) * 4 >= REG_WIDTH);
    end
  endfunction

  localparam logic [DIGITS-1:0] BLANK0 = blank_pattern(0);

  logic nxt_ev, prv_ev, pg_ev;

  reg_display_btn #(.DEBOUNCE(DEBOUNCE)) u_next (
    .Clock(Clock), .Reset(Reset), .raw_i(Next), .press_o(nxt_ev)
  );
  reg_display_btn #(.DEBOUNCE(DEBOUNCE)) u_prev (
    .Clock(Clock), .Reset(Reset), .raw_i(Prev), .press_o(prv_ev)
  );
  reg_display_btn #(.DEBOUNCE(DEBOUNCE)) u_page (
    .Clock(Clock), .Reset(Reset), .raw_i(PageBtn), .press_o(pg_ev)
  );

  logic [SELW-1:0]      sel_q, sel_d;
  logic [PGW-1:0]       page_q, page_d;
  logic [SCW-1:0]       scan_q, scan_d;
  logic                 chg_q, chg_d;
  logic [REG_WIDTH-1:0] v_q, v_d;
  logic [NIBW-1:0]      nib_q, nib_d;
  logic [DIGITS-1:0]    blank_q, blank_d;
  logic [PADW-1:0]      vpad;
  logic                 btn_ev, scan_tc, step_up, step_dn;

  // A button event pre-empts a coincident auto-scan step, so there is never a double step.
  always_comb begin
    btn_ev  = nxt_ev | prv_ev;
    scan_tc = Auto && (scan_q == SCW'(SCAN_DIV - 1));
    step_up = btn_ev ? (nxt_ev & ~prv_ev) : scan_tc;
    step_dn = prv_ev & ~nxt_ev;
    chg_d   = step_up | step_dn;

    scan_d = scan_q + 1'b1;
    if (!Auto || btn_ev || scan_tc) begin
      scan_d = '0;
    end

    sel_d = sel_q;
    if (step_up) begin
      sel_d = (sel_q == SELW'(NUM_REGS - 1)) ? '0 : sel_q + 1'b1;
    end else if (step_dn) begin
      sel_d = (sel_q == '0) ? SELW'(NUM_REGS - 1) : sel_q - 1'b1;
    end

    page_d = page_q;
    if (chg_d) begin
      page_d = '0;
    end else if (pg_ev) begin
      page_d = (page_q == PGW'(PAGES - 1)) ? '0 : page_q + 1'b1;
    end
  end

  // chg_q marks the first cycle with a new selection, which forces one reload while frozen.
  always_comb begin
    v_d = v_q;
    if (!Freeze || chg_q) begin
      v_d = Regs[int'(sel_q) * REG_WIDTH +: REG_WIDTH];
    end

    vpad  = PADW'(v_q);
    nib_d = '0;
    for (int d = 0; d < DIGITS; d++) begin
      nib_d[4*d +: 4] = vpad[(int'(page_q) * DIGITS + d) * 4 +: 4];
    end
    blank_d = blank_pattern(int'(page_q));
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      sel_q   <= '0;
      page_q  <= '0;
      scan_q  <= '0;
      chg_q   <= 1'b0;
      v_q     <= '0;
      nib_q   <= '0;
      blank_q <= BLANK0;
    end else begin
      sel_q   <= sel_d;
      page_q  <= page_d;
      scan_q  <= scan_d;
      chg_q   <= chg_d;
      v_q     <= v_d;
      nib_q   <= nib_d;
      blank_q <= blank_d;
    end
  end

  assign Sel     = sel_q;
  assign Page    = page_q;
  assign Nibbles = nib_q;
  assign Blank   = blank_q;
endmodule

// File: tb/tb_reg_display_scanner.sv
// Self-checking bench for reg_display_scanner: a 16-bit eight-register instance with a
// selection scoreboard, and a 24-bit two-register instance for paging and blanking.
module tb_reg_display_scanner;
  localparam int DB = 4;
  localparam int SD = 10;

  logic         Clock = 1'b0;
  logic         Reset = 1'b0;
  logic [127:0] Regs;
  logic         nxt = 1'b1, prv = 1'b1, pgb = 1'b1, nxt_w = 1'b1;
  logic         one = 1'b1, zero = 1'b0;
  logic         auto_en = 1'b0, frz = 1'b0;
  logic [2:0]   Sel;
  logic [0:0]   Page;
  logic [15:0]  Nibbles;
  logic [3:0]   Blank;

  logic [47:0]  Regs_w;
  logic [23:0]  rw0 = 24'hABCDEF, rw1 = 24'h123456;
  logic [0:0]   Sel_w, Page_w;
  logic [15:0]  Nibbles_w;
  logic [3:0]   Blank_w;

  logic [15:0]  rv [8];
  int           cyc = 0;
  int           base = 0;
  int           checks = 0;
  int           errors = 0;
  logic         mon_en = 1'b0;
  logic [2:0]   last_sel = 3'd0;

  typedef struct packed { logic [2:0] sel; logic [15:0] nib; } sb_t;
  sb_t sbq[$];

  typedef enum int {OP_NEXT, OP_PREV, OP_BOTH, OP_SHORT, OP_BOUNCE} op_e;
  typedef struct { op_e op; logic [2:0] sel; logic chg; } vec_t;
  vec_t tbl [11];

  reg_display_scanner #(.NUM_REGS(8), .REG_WIDTH(16), .DIGITS(4), .DEBOUNCE(DB), .SCAN_DIV(SD)) dut (
    .Clock(Clock), .Reset(Reset), .Regs(Regs), .Next(nxt), .Prev(prv), .PageBtn(pgb),
    .Auto(auto_en), .Freeze(frz), .Sel(Sel), .Page(Page), .Nibbles(Nibbles), .Blank(Blank)
  );

  reg_display_scanner #(.NUM_REGS(2), .REG_WIDTH(24), .DIGITS(4), .DEBOUNCE(DB), .SCAN_DIV(SD)) dut_w (
    .Clock(Clock), .Reset(Reset), .Regs(Regs_w), .Next(nxt_w), .Prev(one), .PageBtn(pgb),
    .Auto(zero), .Freeze(frz), .Sel(Sel_w), .Page(Page_w), .Nibbles(Nibbles_w), .Blank(Blank_w)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  always_comb begin
    for (int i = 0; i < 8; i++) Regs[i*16 +: 16] = rv[i];
    Regs_w = {rw1, rw0};
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: every selection change must match the next queued expectation,
  // and the displayed digits must follow two cycles later.
  always begin
    @(negedge Clock);
    if (!mon_en) begin
      last_sel = Sel;
    end else if (Sel !== last_sel) begin
      last_sel = Sel;
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sel_unexpected got %0d expected no change (t=%0t)", Sel, $time);
      end else begin
        sb_t e;
        e = sbq.pop_front();
        check("sb_sel", 64'(Sel), 64'(e.sel));
        repeat (2) @(negedge Clock);
        check("sb_nibbles", 64'(Nibbles), 64'(e.nib));
      end
    end
  end

  task automatic goto_pos(input int e);
    while (cyc < base + e) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic goto_neg(input int e);
    goto_pos(e);
    @(negedge Clock);
  endtask

  task automatic mark();
    @(posedge Clock);
    #1;
    base = cyc;
  endtask

  task automatic press(input logic [3:0] m);
    {nxt_w, pgb, prv, nxt} = ~m;
    repeat (DB + 2) @(posedge Clock);
    #1;
    {nxt_w, pgb, prv, nxt} = 4'hF;
    repeat (DB + 6) @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic pulse(input int lo, input int hi, input int reps);
    for (int r = 0; r < reps; r++) begin
      nxt = 1'b0;
      repeat (lo) @(posedge Clock);
      #1;
      nxt = 1'b1;
      repeat (hi) @(posedge Clock);
      #1;
    end
  endtask

  task automatic push(input logic [2:0] s);
    sbq.push_back(sb_t'{s, rv[s]});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{OP_NEXT,   3'd1, 1'b1};
    tbl[1]  = '{OP_NEXT,   3'd2, 1'b1};
    tbl[2]  = '{OP_NEXT,   3'd3, 1'b1};
    tbl[3]  = '{OP_PREV,   3'd2, 1'b1};
    tbl[4]  = '{OP_PREV,   3'd1, 1'b1};
    tbl[5]  = '{OP_PREV,   3'd0, 1'b1};
    tbl[6]  = '{OP_PREV,   3'd7, 1'b1};
    tbl[7]  = '{OP_SHORT,  3'd7, 1'b0};
    tbl[8]  = '{OP_BOUNCE, 3'd7, 1'b0};
    tbl[9]  = '{OP_BOTH,   3'd7, 1'b0};
    tbl[10] = '{OP_NEXT,   3'd0, 1'b1};
    for (int i = 0; i < 8; i++) rv[i] = 16'h1111 * 16'(i);

    // Reset state, observed while reset is still held.
    #3;
    check("rst_sel", 64'(Sel), 64'd0);
    check("rst_page", 64'(Page), 64'd0);
    check("rst_nibbles", 64'(Nibbles), 64'h0);
    check("rst_blank", 64'(Blank), 64'b0000);
    check("rst_blank_w", 64'(Blank_w), 64'b0000);
    repeat (3) @(posedge Clock);
    #1;
    Reset = 1'b1;
    repeat (5) @(negedge Clock);
    check("idle_nibbles", 64'(Nibbles), 64'h0000);
    check("idle_nibbles_w", 64'(Nibbles_w), 64'hCDEF);
    mon_en = 1'b1;

    for (int i = 0; i < 11; i++) begin
      if (tbl[i].chg) push(tbl[i].sel);
      case (tbl[i].op)
        OP_NEXT:   press(4'b0001);
        OP_PREV:   press(4'b0010);
        OP_BOTH:   press(4'b0011);
        OP_SHORT:  pulse(DB - 1, DB + 6, 1);
        default:   pulse(3, 2, 4);
      endcase
      repeat (DB + 6) @(negedge Clock);
      check("tbl_sel", 64'(Sel), 64'(tbl[i].sel));
    end

    // Exact press latency: low first sampled at edge 1, held DEBOUNCE cycles.
    mark();
    push(3'd1);
    nxt = 1'b0;
    goto_pos(DB);
    nxt = 1'b1;
    goto_neg(DB + 2);
    check("lat_before", 64'(Sel), 64'd0);
    goto_neg(DB + 3);
    check("lat_edge", 64'(Sel), 64'd1);
    goto_neg(DB + 5);
    check("lat_nibbles", 64'(Nibbles), 64'h1111);
    repeat (20) @(negedge Clock);

    // Auto-scan: one step every SD cycles, first step SD edges after Auto rises.
    mark();
    auto_en = 1'b1;
    for (int k = 1; k <= 8; k++) push(3'((1 + k) % 8));
    for (int k = 1; k <= 8; k++) begin
      goto_neg(SD * k - 1);
      check("scan_hold", 64'(Sel), 64'((k) % 8));
      goto_neg(SD * k);
      check("scan_step", 64'(Sel), 64'((1 + k) % 8));
    end
    auto_en = 1'b0;
    goto_neg(SD * 8 + 30);
    check("scan_off", 64'(Sel), 64'd1);

    // Next landing on the terminal count, then Next mid-scan restarting the counter.
    mark();
    auto_en = 1'b1;
    push(3'd2);
    goto_pos(3);
    nxt = 1'b0;
    goto_pos(9);
    nxt = 1'b1;
    goto_neg(9);
    check("coinc_before", 64'(Sel), 64'd1);
    goto_neg(10);
    check("coinc_single", 64'(Sel), 64'd2);
    push(3'd3);
    goto_neg(19);
    check("coinc_next_hold", 64'(Sel), 64'd2);
    goto_neg(20);
    check("coinc_next_step", 64'(Sel), 64'd3);
    push(3'd4);
    nxt = 1'b0;
    goto_pos(26);
    nxt = 1'b1;
    goto_neg(27);
    check("mid_press", 64'(Sel), 64'd4);
    push(3'd5);
    goto_neg(30);
    check("mid_restart", 64'(Sel), 64'd4);
    goto_neg(36);
    check("mid_hold", 64'(Sel), 64'd4);
    goto_neg(37);
    check("mid_step", 64'(Sel), 64'd5);
    auto_en = 1'b0;
    repeat (20) @(negedge Clock);

    mon_en = 1'b0;
    Reset = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    Reset = 1'b1;
    repeat (5) @(negedge Clock);
    mon_en = 1'b1;
    check("rst2_sel", 64'(Sel), 64'd0);

    // Freeze: held value, one reload on selection change, live again when released.
    frz = 1'b1;
    repeat (3) @(negedge Clock);
    rv[0] = 16'hBEEF;
    repeat (5) @(negedge Clock);
    check("frz_hold", 64'(Nibbles), 64'h0000);
    push(3'd1);
    press(4'b0001);
    rv[1] = 16'h1234;
    repeat (5) @(negedge Clock);
    check("frz_sel_hold", 64'(Nibbles), 64'h1111);
    frz = 1'b0;
    repeat (3) @(negedge Clock);
    check("frz_live", 64'(Nibbles), 64'h1234);
    push(3'd0);
    press(4'b0010);
    repeat (5) @(negedge Clock);
    check("frz_prev_live", 64'(Nibbles), 64'hBEEF);

    // Reset mid-scan and mid-debounce discards all progress.
    mark();
    auto_en = 1'b1;
    goto_pos(6);
    nxt = 1'b0;
    goto_pos(8);
    mon_en = 1'b0;
    #2;
    Reset = 1'b0;
    #1;
    check("async_nibbles", 64'(Nibbles), 64'h0);
    check("async_sel", 64'(Sel), 64'd0);
    nxt = 1'b1;
    mark();
    Reset = 1'b1;
    push(3'd1);
    mon_en = 1'b1;
    goto_neg(SD - 1);
    check("rstscan_hold", 64'(Sel), 64'd0);
    goto_neg(SD);
    check("rstscan_step", 64'(Sel), 64'd1);
    auto_en = 1'b0;
    repeat (10) @(negedge Clock);

    // Paging on the 24-bit instance.
    check("pg0_page", 64'(Page_w), 64'd0);
    check("pg0_nibbles", 64'(Nibbles_w), 64'hCDEF);
    check("pg0_blank", 64'(Blank_w), 64'b0000);
    press(4'b0100);
    check("pg1_page", 64'(Page_w), 64'd1);
    check("pg1_nibbles", 64'(Nibbles_w), 64'h00AB);
    check("pg1_blank", 64'(Blank_w), 64'b1100);
    check("single_page", 64'(Page), 64'd0);
    frz = 1'b1;
    repeat (3) @(negedge Clock);
    rw0 = 24'h111111;
    press(4'b0100);
    check("pgwrap_page", 64'(Page_w), 64'd0);
    check("pgfrz_nibbles", 64'(Nibbles_w), 64'hCDEF);
    press(4'b0100);
    check("pgfrz1_nibbles", 64'(Nibbles_w), 64'h00AB);
    press(4'b1000);
    check("pgsel_sel", 64'(Sel_w), 64'd1);
    check("pgsel_page", 64'(Page_w), 64'd0);
    check("pgsel_nibbles", 64'(Nibbles_w), 64'h3456);
    frz = 1'b0;
    press(4'b0100);
    check("pgsel1_nibbles", 64'(Nibbles_w), 64'h0012);
    check("pgsel1_blank", 64'(Blank_w), 64'b1100);

    check("sb_drained", 64'(sbq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_display_scanner.md
# reg_display_scanner

Parametrised register-file viewer that selects one of `NUM_REGS` processor registers and presents it as hex digits for the 7-segment decoders. It sits between the processor's register outputs and the `binary_to_7Seg` instances on the board top level. It adds the following over a plain select-and-slice viewer:
- debounced Next/Prev/Page buttons;
- an auto-scan mode;
- a freeze/snapshot hold;
- paging for registers wider than the digit count.

## Interface
Parameters:
- `NUM_REGS`, 8: number of registers viewed (2..256).
- `REG_WIDTH`, 16: width of each register in bits (1..64).
- `DIGITS`, 4: number of hex digits driven.
- `DEBOUNCE`, 16: number of consecutive stable cycles required to accept a button level (≥1).
- `SCAN_DIV`, 1000: clock cycles per auto-scan step (≥2).
- Derived values:
  - `SELW = max(1, clog2(NUM_REGS))`.
  - `PAGES = ceil(REG_WIDTH / (4*DIGITS))`.
  - `PGW = max(1, clog2(PAGES))`.

Ports:
- `Clock` input 1: single system clock, rising edge.
- `Reset` input 1: asynchronous, active-low reset.
- `Regs` input `NUM_REGS*REG_WIDTH`: flat register bus, register i at bits `[i*REG_WIDTH +: REG_WIDTH]`.
- `Next` input 1: raw active-low pushbutton that advances the selection.
- `Prev` input 1: raw active-low pushbutton that steps the selection back.
- `PageBtn` input 1: raw active-low pushbutton that advances the page.
- `Auto` input 1: level input; 1 enables auto-scan.
- `Freeze` input 1: level input; 1 holds the displayed value.
- `Sel` output `SELW`: index of the currently selected register.
- `Page` output `PGW`: index of the currently displayed page.
- `Nibbles` output `4*DIGITS`: displayed digits; digit d is at `[4d +: 4]`, and d=0 is least significant.
- `Blank` output `DIGITS`: 1 means digit d lies beyond `REG_WIDTH` on the current page and should be blanked.

## Operation
Button conditioning, identical per button:
- Each raw input passes through a 2-flop synchroniser.
- A counter counts cycles in which the synchronised level differs from the debounced state.
- The counter clears whenever the two levels match.
- The debounced state flips after `DEBOUNCE` consecutive differing cycles.
- A press event is a 1-cycle pulse on the debounced 1→0 transition. A release generates no event.

Selection:
- Next: `Sel ← Sel+1`, wrapping from `NUM_REGS-1` to 0.
- Prev: `Sel ← Sel-1`, wrapping from 0 to `NUM_REGS-1`.
- Next and Prev events in the same cycle: `Sel` is unchanged.
- Any selection change resets `Page` to 0.

Paging:
- A PageBtn event gives `Page ← Page+1`, wrapping from `PAGES-1` to 0.
- When `PAGES == 1`, `Page` stays 0.

Auto-scan:
- While `Auto=1`, a scan counter counts 0..`SCAN_DIV-1`.
- At terminal count the block performs an implicit Next.
- A Next or Prev event clears the scan counter. The button event takes effect; no double step occurs.
- While `Auto=0`, the counter is held at 0.

Display value `V`:
- When `Freeze=0`, `V` is loaded every cycle from the selected register.
- When `Freeze=1`, `V` holds.
- Exception: a selection change while frozen loads the newly selected register once, then holds again.

Digit mapping:
- Digit d on page p shows `V[(p*DIGITS+d)*4 +: 4]`.
- Bits at or above `REG_WIDTH` read as 0.
- A partial top nibble is zero-extended.
- `Blank[d] = 1` iff `(p*DIGITS+d)*4 ≥ REG_WIDTH`. When `Blank[d] = 1`, that digit's nibble is 0.

## Timing
- Reset values, applied asynchronously on `Reset=0`:
  - `Sel=0`, `Page=0`, `V=0`, `Nibbles=0`.
  - `Blank` = the page-0 pattern.
  - Synchronisers and debounced states = 1 (released).
  - All counters = 0.
- Reset asserted mid-debounce or mid-scan discards all progress. No event is produced on release of reset.
- Press latency: the raw input is sampled low at edge 1 and stays low. The synchronised level is low after edge 2. The debounced state falls at edge `2+DEBOUNCE`. `Sel` or `Page` updates at edge `3+DEBOUNCE`.
- A glitch shorter than `DEBOUNCE` cycles produces no event.
- Register-to-display latency:
  - `V` updates one edge after `Regs` or `Sel` changes.
  - `Nibbles` and `Blank` are registered and update one edge after `V` or `Page` changes. Total latency is 2 cycles.
- Auto-scan: with no buttons pressed, `Sel` steps exactly every `SCAN_DIV` cycles. The first step occurs `SCAN_DIV` edges after `Auto` rises.
- A page change when `Freeze=1` re-slices the held `V`. No reload occurs.

## Test plan
- **Reset and select:** reset, then `Regs` register i = `16'h1111*i`. Expect `Sel=0` and `Nibbles=16'h0000`. Press Next 3 times: `Sel=3`, `Nibbles=16'h3333` 2 cycles after each `Sel` update. Press Prev 4 times: `Sel=7`.
- **Debounce:**
  - Hold Next low for `DEBOUNCE-1` cycles, then release: no change.
  - Hold for `DEBOUNCE` cycles: `Sel` increments at edge `3+DEBOUNCE`.
  - A bouncing pattern of 3-cycle pulses: at most one increment.
- **Simultaneous events:** Next and Prev debounced in the same cycle: `Sel` unchanged. Next coincident with an auto-scan terminal count: a single increment, and the scan counter restarts.
- **Auto-scan:** with `SCAN_DIV=10`, `Auto=1`, `Sel` steps 0→1→…→7→0 at cycles 10, 20, …, 80. Drop `Auto`: `Sel` holds.
- **Freeze:**
  - `Freeze=1`, then change `Regs[0]` to `16'hBEEF`: `Nibbles` unchanged.
  - Press Next: the new register is shown once, then held.
  - `Freeze=0`: `Nibbles` tracks live values.
- **Paging and width:**
  - `REG_WIDTH=24`, `DIGITS=4`, register value `24'hABCDEF`.
  - Page 0: `Nibbles=16'hCDEF`, `Blank=4'b0000`.
  - PageBtn: `Page=1`, `Nibbles=16'h00AB`, `Blank=4'b1100`.
  - PageBtn again: `Page=0`.
